// File: rtl/ibex_fetch_req_ctrl_if.sv
// Instruction-bus handshake bundle between the fetch request controller and the memory side.
interface ibex_fetch_req_ctrl_if;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;

  modport master (
    output instr_req_o,
    output instr_addr_o,
    input  instr_gnt_i,
    input  instr_rvalid_i,
    input  instr_rdata_i,
    input  instr_err_i
  );

  modport slave (
    input  instr_req_o,
    input  instr_addr_o,
    output instr_gnt_i,
    output instr_rvalid_i,
    output instr_rdata_i,
    output instr_err_i
  );
endinterface

// File: rtl/ibex_fetch_req_ctrl.sv
// Fetch request controller: issues word-aligned instruction-bus requests, tracks outstanding
// responses in order and forwards non-discarded responses to the fetch FIFO with zero latency.
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  output logic        busy_o,
  ibex_fetch_req_ctrl_if.master bus,
  output logic        fifo_clear_o,
  output logic [31:0] fifo_addr_o,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_rdata_o,
  output logic        fifo_err_o,
  input  logic        fifo_ready_i
);

  logic [31:2]         fetch_addr_q, fetch_addr_d;
  logic [31:2]         stored_addr_q, stored_addr_d;
  logic                stored_valid_q, stored_valid_d;
  logic [31:2]         held_addr_q, held_addr_d;
  logic                held_discard_q, held_discard_d;
  logic                pending_q, pending_d;
  logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;

  logic        new_req;
  logic        req;
  logic        granted;
  logic        retire;
  logic        append_discard;
  logic        placed;
  logic [31:2] addr_word;

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;

  // outstanding_q is filled from index 0 upwards, so the top bit alone means "full".
  assign new_req = req_i & fifo_ready_i & ~outstanding_q[NUM_REQS-1] & ~pending_q;
  assign req     = rst_ni & (new_req | pending_q);
  assign granted = req & bus.instr_gnt_i;
  assign retire  = bus.instr_rvalid_i & outstanding_q[0];

  assign addr_word = pending_q      ? held_addr_q   :
                     branch_i       ? addr_i[31:2]  :
                     stored_valid_q ? stored_addr_q : fetch_addr_q;

  // A held request targets a stale address once any branch has passed it by.
  assign append_discard = pending_q & (held_discard_q | branch_i);

  assign bus.instr_req_o  = req;
  assign bus.instr_addr_o = {addr_word, 2'b00};

  assign fifo_valid_o = retire & ~discard_q[0] & ~branch_i;
  assign fifo_rdata_o = bus.instr_rdata_i;
  assign fifo_err_o   = bus.instr_err_i;
  assign busy_o       = req | (|outstanding_q);

  always_comb begin
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    placed        = 1'b0;
    if (retire) begin
      outstanding_d = outstanding_q >> 1;
      discard_d     = discard_q >> 1;
    end
    if (branch_i) begin
      discard_d = discard_d | outstanding_d;
    end
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (granted && !placed && !outstanding_d[i]) begin
        outstanding_d[i] = 1'b1;
        discard_d[i]     = append_discard;
        placed           = 1'b1;
      end
    end
  end

  always_comb begin
    fetch_addr_d   = fetch_addr_q;
    stored_addr_d  = stored_addr_q;
    stored_valid_d = stored_valid_q;
    held_addr_d    = held_addr_q;
    held_discard_d = held_discard_q;
    pending_d      = req & ~bus.instr_gnt_i;

    if (req && !bus.instr_gnt_i && !pending_q) begin
      held_addr_d    = addr_word;
      held_discard_d = 1'b0;
    end

    if (branch_i) begin
      if (pending_q && !bus.instr_gnt_i) begin
        stored_addr_d  = addr_i[31:2];
        stored_valid_d = 1'b1;
        held_discard_d = 1'b1;
      end else begin
        stored_valid_d = 1'b0;
        fetch_addr_d   = (granted && !pending_q) ? 30'(addr_i[31:2] + 30'd1) : addr_i[31:2];
      end
    end else if (granted && !append_discard) begin
      fetch_addr_d   = 30'(addr_word + 30'd1);
      stored_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_q   <= '0;
      stored_addr_q  <= '0;
      stored_valid_q <= 1'b0;
      held_addr_q    <= '0;
      held_discard_q <= 1'b0;
      pending_q      <= 1'b0;
      outstanding_q  <= '0;
      discard_q      <= '0;
    end else begin
      fetch_addr_q   <= fetch_addr_d;
      stored_addr_q  <= stored_addr_d;
      stored_valid_q <= stored_valid_d;
      held_addr_q    <= held_addr_d;
      held_discard_q <= held_discard_d;
      pending_q      <= pending_d;
      outstanding_q  <= outstanding_d;
      discard_q      <= discard_d;
    end
  end

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Scenario-driven bench for ibex_fetch_req_ctrl; expected FIFO pushes are queued as responses
// are driven and matched by a monitor when the DUT pushes.
module tb_ibex_fetch_req_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        busy_o;
  logic        fifo_clear_o;
  logic [31:0] fifo_addr_o;
  logic        fifo_valid_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_err_o;
  logic        fifo_ready_i;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } push_t;
  push_t exp_q[$];

  ibex_fetch_req_ctrl_if bus ();

  ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .branch_i     (branch_i),
    .addr_i       (addr_i),
    .busy_o       (busy_o),
    .bus          (bus.master),
    .fifo_clear_o (fifo_clear_o),
    .fifo_addr_o  (fifo_addr_o),
    .fifo_valid_o (fifo_valid_o),
    .fifo_rdata_o (fifo_rdata_o),
    .fifo_err_o   (fifo_err_o),
    .fifo_ready_i (fifo_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard side: every push must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (fifo_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push: got data %h err %b, no push expected",
                 fifo_rdata_o, fifo_err_o);
      end else begin
        push_t e;
        e = exp_q.pop_front();
        if (fifo_rdata_o !== e.data || fifo_err_o !== e.err) begin
          errors++;
          $display("FAIL push_data: got %h/%b expected %h/%b", fifo_rdata_o, fifo_err_o,
                   e.data, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    req_i              = 1'b0;
    branch_i           = 1'b0;
    addr_i             = 32'h0;
    fifo_ready_i       = 1'b1;
    bus.instr_gnt_i    = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.instr_rdata_i  = 32'h0;
    bus.instr_err_i    = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic err, input bit expect_push);
    bus.instr_rvalid_i = 1'b1;
    bus.instr_rdata_i  = data;
    bus.instr_err_i    = err;
    if (expect_push) exp_q.push_back('{data: data, err: err});
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: pending pushes %0d busy %b, expected 0 and 0", name,
               exp_q.size(), busy_o);
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_ni   = 1'b0;
    req_i    = 1'b1;
    branch_i = 1'b1;
    addr_i   = 32'h0000_1234;
    bus.instr_rvalid_i = 1'b1;
    #12;
    checks++;
    if (bus.instr_req_o !== 1'b0 || busy_o !== 1'b0 || fifo_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req %b busy %b valid %b, expected 0 0 0",
               bus.instr_req_o, busy_o, fifo_valid_o);
    end
    checks++;
    if (fifo_clear_o !== 1'b1 || fifo_addr_o !== 32'h0000_1234) begin
      errors++;
      $display("FAIL reset_fifo_passthru: clear %b addr %h, expected 1 00001234",
               fifo_clear_o, fifo_addr_o);
    end
    idle_inputs();
    tick();
    rst_ni = 1'b1;
    #1;
    req_i = 1'b1;
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_fetch_addr: req %b addr %h, expected 1 00000000",
               bus.instr_req_o, bus.instr_addr_o);
    end
    req_i = 1'b0;
    tick();
  endtask

  task automatic test_branch_basic;
    idle_inputs();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h100; bus.instr_gnt_i = 1'b1;
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h100 || fifo_clear_o !== 1'b1) begin
      errors++;
      $display("FAIL branch_first_addr: req %b addr %h clear %b, expected 1 00000100 1",
               bus.instr_req_o, bus.instr_addr_o, fifo_clear_o);
    end
    tick();
    branch_i = 1'b0; bus.instr_gnt_i = 1'b0;
    respond(32'hDEAD_BEEF, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.instr_addr_o !== 32'h104 || fifo_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL branch_next_addr: addr %h valid %b, expected 00000104 1",
               bus.instr_addr_o, fifo_valid_o);
    end
    tick();
    bus.instr_rvalid_i = 1'b0;
    req_i = 1'b0; bus.instr_gnt_i = 1'b1;
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h104) begin
      errors++;
      $display("FAIL held_after_req_drop: req %b addr %h, expected 1 00000104",
               bus.instr_req_o, bus.instr_addr_o);
    end
    tick();
    bus.instr_gnt_i = 1'b0;
    respond(32'h1111_1111, 1'b0, 1'b1);
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_outstanding: busy %b, expected 1", busy_o);
    end
    tick();
    idle_inputs();
    #1;
    check_drained("branch_basic");
  endtask

  task automatic test_max_outstanding;
    int grants = 0;
    logic [31:0] gaddr[2];
    gaddr[0] = '0; gaddr[1] = '0;
    idle_inputs();
    req_i = 1'b1; bus.instr_gnt_i = 1'b1; branch_i = 1'b1; addr_i = 32'h100;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.instr_req_o === 1'b1) begin
        if (grants < 2) gaddr[grants] = bus.instr_addr_o;
        grants++;
      end
      tick();
      branch_i = 1'b0;
    end
    checks++;
    if (grants != 2 || gaddr[0] !== 32'h100 || gaddr[1] !== 32'h104) begin
      errors++;
      $display("FAIL max_outstanding: grants %0d addrs %h %h, expected 2 00000100 00000104",
               grants, gaddr[0], gaddr[1]);
    end
    respond(32'h0000_00A0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL full_no_req: req %b, expected 0", bus.instr_req_o);
    end
    tick();
    bus.instr_rvalid_i = 1'b0;
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h108) begin
      errors++;
      $display("FAIL req_after_retire: req %b addr %h, expected 1 00000108",
               bus.instr_req_o, bus.instr_addr_o);
    end
    tick();
    req_i = 1'b0; bus.instr_gnt_i = 1'b0;
    respond(32'h0000_00A1, 1'b0, 1'b1);
    tick();
    respond(32'h0000_00A2, 1'b0, 1'b1);
    tick();
    idle_inputs();
    #1;
    check_drained("max_outstanding");
  endtask

  task automatic test_branch_while_pending;
    idle_inputs();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h108;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin branch_i = 1'b1; addr_i = 32'h202; end
      else branch_i = (c == 0);
      if (c == 3) bus.instr_gnt_i = 1'b1;
      #1;
      checks++;
      if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h108) begin
        errors++;
        $display("FAIL held_stable_c%0d: req %b addr %h, expected 1 00000108", c,
                 bus.instr_req_o, bus.instr_addr_o);
      end
      tick();
    end
    branch_i = 1'b0;
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL stored_target: req %b addr %h, expected 1 00000200",
               bus.instr_req_o, bus.instr_addr_o);
    end
    tick();
    req_i = 1'b0; bus.instr_gnt_i = 1'b0;
    respond(32'h0000_0BAD, 1'b0, 1'b0);
    #1;
    checks++;
    if (fifo_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stale_dropped: valid %b, expected 0", fifo_valid_o);
    end
    tick();
    respond(32'h0000_200D, 1'b0, 1'b1);
    tick();
    bus.instr_rvalid_i = 1'b0; req_i = 1'b1;
    #1;
    checks++;
    if (bus.instr_addr_o !== 32'h204) begin
      errors++;
      $display("FAIL after_stored: addr %h, expected 00000204", bus.instr_addr_o);
    end
    tick();
    req_i = 1'b0; bus.instr_gnt_i = 1'b1;
    tick();
    bus.instr_gnt_i = 1'b0;
    respond(32'h0000_204D, 1'b0, 1'b1);
    tick();
    idle_inputs();
    #1;
    check_drained("branch_pending");
  endtask

  task automatic test_branch_flush;
    idle_inputs();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h300; bus.instr_gnt_i = 1'b1;
    tick();
    branch_i = 1'b0;
    tick();
    branch_i = 1'b1; addr_i = 32'h40; bus.instr_gnt_i = 1'b0;
    tick();
    branch_i = 1'b0; req_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      respond(32'hF00D_0000 + c, 1'b0, 1'b0);
      #1;
      checks++;
      if (fifo_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flushed_resp%0d: valid %b, expected 0", c, fifo_valid_o);
      end
      tick();
    end
    bus.instr_rvalid_i = 1'b0; req_i = 1'b1; bus.instr_gnt_i = 1'b1;
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h40) begin
      errors++;
      $display("FAIL flush_target: req %b addr %h, expected 1 00000040",
               bus.instr_req_o, bus.instr_addr_o);
    end
    tick();
    req_i = 1'b0; bus.instr_gnt_i = 1'b0;
    respond(32'h0000_040D, 1'b0, 1'b1);
    tick();
    idle_inputs();
    #1;
    check_drained("branch_flush");
  endtask

  task automatic test_fifo_not_ready_err;
    idle_inputs();
    fifo_ready_i = 1'b0; req_i = 1'b1;
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL not_ready_no_req: req %b, expected 0", bus.instr_req_o);
    end
    tick();
    fifo_ready_i = 1'b1;
    tick();
    fifo_ready_i = 1'b0; req_i = 1'b0;
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h44) begin
      errors++;
      $display("FAIL pending_survives: req %b addr %h, expected 1 00000044",
               bus.instr_req_o, bus.instr_addr_o);
    end
    tick();
    bus.instr_gnt_i = 1'b1;
    tick();
    bus.instr_gnt_i = 1'b0;
    respond(32'h0000_000E, 1'b1, 1'b1);
    #1;
    checks++;
    if (fifo_valid_o !== 1'b1 || fifo_err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_push: valid %b err %b, expected 1 1", fifo_valid_o, fifo_err_o);
    end
    tick();
    idle_inputs();
    #1;
    check_drained("not_ready_err");
  endtask

  task automatic test_reset_mid;
    idle_inputs();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h500; bus.instr_gnt_i = 1'b1;
    tick();
    branch_i = 1'b0;
    tick();
    rst_ni = 1'b0; branch_i = 1'b1; addr_i = 32'h0000_0ABC;
    respond(32'h0000_DEAD, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.instr_req_o !== 1'b0 || busy_o !== 1'b0 || fifo_valid_o !== 1'b0 ||
        fifo_clear_o !== 1'b1 || fifo_addr_o !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL mid_reset: req %b busy %b valid %b clear %b addr %h, expected 0 0 0 1 00000abc",
               bus.instr_req_o, busy_o, fifo_valid_o, fifo_clear_o, fifo_addr_o);
    end
    tick();
    req_i = 1'b0; branch_i = 1'b0; bus.instr_gnt_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    checks++;
    if (fifo_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL late_resp: valid %b busy %b, expected 0 0", fifo_valid_o, busy_o);
    end
    tick();
    idle_inputs();
    #1;
    check_drained("reset_mid");
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    test_reset();
    test_branch_basic();
    test_max_outstanding();
    test_branch_while_pending();
    test_branch_flush();
    test_fifo_not_ready_err();
    test_reset_mid();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
